// File: rtl/load_store_align.sv
// Load/store alignment unit: maps byte/half/word requests onto a word-wide memory,
// merging sub-word stores and splitting word-straddling accesses across two cycles.
module load_store_align #(
  parameter bit MISALIGNED_EN = 1'b1
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        mem_wr_en,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_write_data,
  input  logic [31:0] mem_read_data,
  output logic [31:0] ld_data,
  output logic        ld_valid,
  output logic        stall,
  output logic        misalign_err
);

  typedef enum logic {IDLE, SECOND} state_t;

  state_t      state, state_nxt;
  logic [23:0] hold_q, hold_nxt;

  logic [2:0]  size_b;
  logic        op_ok;
  logic        sext;
  logic [1:0]  offset;
  logic        straddle;
  logic [31:0] size_mask;
  logic [4:0]  sh_lo;
  logic [5:0]  sh_hi;
  logic [29:0] word_idx;

  logic [31:0] lane_mask_lo, lane_mask_hi;
  logic [31:0] wdata_lo, wdata_hi;
  logic [31:0] merged_lo, merged_hi;
  logic [31:0] raw_lo, raw_hi;

  function automatic logic [31:0] extend(input logic [31:0] raw,
                                         input logic [2:0]  size,
                                         input logic        signed_ld);
    logic [31:0] res;
    case (size)
      3'd1:    res = signed_ld ? {{24{raw[7]}},  raw[7:0]}  : {24'h0, raw[7:0]};
      3'd2:    res = signed_ld ? {{16{raw[15]}}, raw[15:0]} : {16'h0, raw[15:0]};
      default: res = raw;
    endcase
    return res;
  endfunction

  // Decode access size; BU/HU are only meaningful for loads.
  always_comb begin
    size_b = 3'd0;
    op_ok  = 1'b0;
    sext   = 1'b0;
    case (req_funct3)
      3'b000: begin size_b = 3'd1; op_ok = 1'b1;    sext = 1'b1; end
      3'b001: begin size_b = 3'd2; op_ok = 1'b1;    sext = 1'b1; end
      3'b010: begin size_b = 3'd4; op_ok = 1'b1;                 end
      3'b100: begin size_b = 3'd1; op_ok = !req_we;              end
      3'b101: begin size_b = 3'd2; op_ok = !req_we;              end
      default: ;
    endcase
  end

  assign offset    = req_addr[1:0];
  assign straddle  = op_ok && (({1'b0, offset} + size_b) > 3'd4);
  assign size_mask = (size_b == 3'd1) ? 32'h0000_00FF :
                     (size_b == 3'd2) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  assign sh_lo     = {offset, 3'b000};
  assign sh_hi     = 6'd32 - {1'b0, offset, 3'b000};

  // The second beat always targets the next word; the index wraps at 2^30.
  assign word_idx  = (state == SECOND) ? (req_addr[31:2] + 30'd1) : req_addr[31:2];
  assign mem_addr  = {word_idx, 2'b00};

  // First beat covers lanes o..3, second beat covers lanes 0..o+s-5.
  assign lane_mask_lo = size_mask << sh_lo;
  assign wdata_lo     = req_wdata << sh_lo;
  assign lane_mask_hi = size_mask >> sh_hi;
  assign wdata_hi     = req_wdata >> sh_hi;
  assign merged_lo    = (mem_read_data & ~lane_mask_lo) | (wdata_lo & lane_mask_lo);
  assign merged_hi    = (mem_read_data & ~lane_mask_hi) | (wdata_hi & lane_mask_hi);
  assign raw_lo       = mem_read_data >> sh_lo;
  assign raw_hi       = (mem_read_data << sh_hi) | {8'h00, hold_q};

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      hold_q <= 24'h0;
    end else begin
      state  <= state_nxt;
      hold_q <= hold_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    hold_nxt  = hold_q;
    case (state)
      IDLE: begin
        if (req_valid && straddle && MISALIGNED_EN) begin
          state_nxt = SECOND;
          if (!req_we) hold_nxt = raw_lo[23:0];
        end
      end
      SECOND: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs are forced quiet while reset is held, even with a request present.
  always_comb begin
    mem_wr_en      = 1'b0;
    mem_write_data = merged_lo;
    ld_data        = 32'h0;
    ld_valid       = 1'b0;
    stall          = 1'b0;
    misalign_err   = 1'b0;
    if (rst_n && req_valid && op_ok) begin
      case (state)
        IDLE: begin
          if (straddle && !MISALIGNED_EN) begin
            misalign_err = 1'b1;
          end else begin
            stall = straddle;
            if (req_we) begin
              mem_wr_en      = 1'b1;
              mem_write_data = merged_lo;
            end else if (!straddle) begin
              ld_valid = 1'b1;
              ld_data  = extend(raw_lo, size_b, sext);
            end
          end
        end
        SECOND: begin
          if (req_we) begin
            mem_wr_en      = 1'b1;
            mem_write_data = merged_hi;
          end else begin
            ld_valid = 1'b1;
            ld_data  = extend(raw_hi, size_b, sext);
          end
        end
        default: ;
      endcase
    end
  end

endmodule
